// File: rtl/pipe_reg_skid.sv
// Elastic pipeline-stage register: one main entry drives the outputs, one skid
// entry absorbs the extra word that arrives while downstream stalls.
module pipe_reg_skid #(
  parameter int                DATA_W      = 32,
  parameter int                CTRL_W      = 4,
  parameter logic [CTRL_W-1:0] BUBBLE_CTRL = {CTRL_W{1'b0}}
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  // State encodes occupancy directly, so the occupancy port is a plain register.
  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] FULL  = 2'd2;

  logic [1:0]        state_r;
  logic [1:0]        state_s;
  logic [CTRL_W-1:0] main_ctrl_r;
  logic [DATA_W-1:0] main_data_r;
  logic [CTRL_W-1:0] skid_ctrl_r;
  logic [DATA_W-1:0] skid_data_r;

  logic main_valid_s;
  logic skid_valid_s;
  logic acc_s;
  logic take_s;
  logic main_ld_in_s;
  logic main_ld_skid_s;
  logic main_clr_s;
  logic skid_ld_s;

  assign main_valid_s = (state_r != EMPTY);
  assign skid_valid_s = (state_r == FULL);
  // in_ready decodes registers only; out_ready never reaches it combinationally.
  assign in_ready     = !skid_valid_s && !RST;
  assign acc_s        = in_valid && in_ready;
  assign take_s       = main_valid_s && out_ready;

  assign out_valid    = main_valid_s;
  assign out_ctrl     = main_ctrl_r;
  assign out_data     = main_data_r;
  assign occupancy    = state_r;

  // Next-state: occupancy transitions with flush taking priority.
  always_comb begin
    state_s = state_r;
    if (flush) begin
      state_s = EMPTY;
    end else begin
      case (state_r)
        EMPTY: begin
          if (acc_s) state_s = ONE;
          else       state_s = EMPTY;
        end
        ONE: begin
          if (take_s && !acc_s)      state_s = EMPTY;
          else if (!take_s && acc_s) state_s = FULL;
          else                       state_s = ONE;
        end
        FULL: begin
          if (take_s) state_s = ONE;
          else        state_s = FULL;
        end
        default: state_s = EMPTY;
      endcase
    end
  end

  // Datapath load selects derived from the current state and handshakes.
  always_comb begin
    main_ld_in_s   = 1'b0;
    main_ld_skid_s = 1'b0;
    main_clr_s     = 1'b0;
    skid_ld_s      = 1'b0;
    if (flush) begin
      main_clr_s = 1'b1;
    end else begin
      case (state_r)
        EMPTY: begin
          if (acc_s) main_ld_in_s = 1'b1;
          else       main_clr_s   = 1'b1;
        end
        ONE: begin
          if (take_s && acc_s) main_ld_in_s = 1'b1;
          else if (take_s)     main_clr_s   = 1'b1;
          else if (acc_s)      skid_ld_s    = 1'b1;
          else                 main_clr_s   = 1'b0;
        end
        FULL: begin
          if (take_s) main_ld_skid_s = 1'b1;
          else        main_ld_skid_s = 1'b0;
        end
        default: main_clr_s = 1'b1;
      endcase
    end
  end

  // State and bundle registers; clearing main forces the bubble control
  // value but leaves data untouched.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r     <= EMPTY;
      main_ctrl_r <= BUBBLE_CTRL;
      main_data_r <= {DATA_W{1'b0}};
      skid_ctrl_r <= BUBBLE_CTRL;
      skid_data_r <= {DATA_W{1'b0}};
    end else begin
      state_r <= state_s;
      if (main_ld_in_s) begin
        main_ctrl_r <= in_ctrl;
        main_data_r <= in_data;
      end else if (main_ld_skid_s) begin
        main_ctrl_r <= skid_ctrl_r;
        main_data_r <= skid_data_r;
      end else if (main_clr_s) begin
        main_ctrl_r <= BUBBLE_CTRL;
      end else begin
        main_ctrl_r <= main_ctrl_r;
      end
      if (skid_ld_s) begin
        skid_ctrl_r <= in_ctrl;
        skid_data_r <= in_data;
      end else begin
        skid_ctrl_r <= skid_ctrl_r;
      end
    end
  end

endmodule

// File: tb/tb_pipe_reg_skid.sv
// Directed and randomized checks for pipe_reg_skid with default parameters
// (DATA_W=32, CTRL_W=4, BUBBLE_CTRL=0).
module tb_pipe_reg_skid;

  logic        CLK = 1'b0;
  logic        RST;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_ctrl;
  logic [31:0] in_data;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_ctrl;
  logic [31:0] out_data;
  logic [1:0]  occupancy;

  int vectors = 0;
  int miscompares = 0;

  typedef struct packed {
    logic [3:0]  c;
    logic [31:0] d;
  } ent_t;

  pipe_reg_skid dut (
    .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready),
    .in_ctrl(in_ctrl), .in_data(in_data), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl),
    .out_data(out_data), .occupancy(occupancy)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RST = 1'b1; in_valid = 1'b0; in_ctrl = 4'h0; in_data = 32'h0;
    flush = 1'b0; out_ready = 1'b0;
    tick(); tick();
    vectors++;
    if ({in_ready, out_valid, out_ctrl, out_data, occupancy} !== {1'b0, 1'b0, 4'h0, 32'h0, 2'd0}) begin
      miscompares++;
      $display("FAIL reset_state got rdy=%b v=%b c=%h d=%h occ=%0d want 0 0 0 0 0",
               in_ready, out_valid, out_ctrl, out_data, occupancy);
    end
    RST = 1'b0;
    #1;
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_release_ready got %b want 1", in_ready);
    end
  endtask

  task automatic test_stream();
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_data = 32'(i); in_ctrl = 4'(i);
      tick();
      vectors++;
      if (out_valid !== 1'b1 || out_data !== 32'(i) || out_ctrl !== 4'(i) || occupancy !== 2'd1) begin
        miscompares++;
        $display("FAIL stream_%0d got v=%b d=%h c=%h occ=%0d want 1 %h %h 1",
                 i, out_valid, out_data, out_ctrl, occupancy, i, i);
      end
    end
    in_valid = 1'b0;
    tick();
    vectors++;
    if (out_valid !== 1'b0 || occupancy !== 2'd0 || out_ctrl !== 4'h0) begin
      miscompares++;
      $display("FAIL stream_drain got v=%b occ=%0d c=%h want 0 0 0", out_valid, occupancy, out_ctrl);
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0; in_valid = 1'b1;
    in_data = 32'hA; in_ctrl = 4'h3;
    tick();
    in_data = 32'hB; in_ctrl = 4'h5;
    tick();
    in_valid = 1'b0;
    vectors++;
    if (occupancy !== 2'd2 || in_ready !== 1'b0 || out_data !== 32'hA || out_ctrl !== 4'h3) begin
      miscompares++;
      $display("FAIL bp_full got occ=%0d rdy=%b d=%h c=%h want 2 0 a 3", occupancy, in_ready, out_data, out_ctrl);
    end
    tick();
    vectors++;
    if (occupancy !== 2'd2 || out_valid !== 1'b1 || out_data !== 32'hA) begin
      miscompares++;
      $display("FAIL bp_hold got occ=%0d v=%b d=%h want 2 1 a", occupancy, out_valid, out_data);
    end
    out_ready = 1'b1;
    tick();
    vectors++;
    if (out_valid !== 1'b1 || out_data !== 32'hB || out_ctrl !== 4'h5 || occupancy !== 2'd1 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_release got v=%b d=%h c=%h occ=%0d rdy=%b want 1 b 5 1 1",
               out_valid, out_data, out_ctrl, occupancy, in_ready);
    end
    tick();
    vectors++;
    if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
      miscompares++;
      $display("FAIL bp_empty got v=%b occ=%0d want 0 0", out_valid, occupancy);
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b0; in_valid = 1'b1;
    in_data = 32'hC; in_ctrl = 4'h6;
    tick();
    in_data = 32'hD; in_ctrl = 4'h7;
    tick();
    flush = 1'b1; in_data = 32'hE; in_ctrl = 4'h8;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    vectors++;
    if (out_valid !== 1'b0 || out_ctrl !== 4'h0 || occupancy !== 2'd0 || out_data !== 32'hC) begin
      miscompares++;
      $display("FAIL flush_full got v=%b c=%h occ=%0d d=%h want 0 0 0 c", out_valid, out_ctrl, occupancy, out_data);
    end
    out_ready = 1'b1;
    tick();
    vectors++;
    if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
      miscompares++;
      $display("FAIL flush_no_emit got v=%b occ=%0d want 0 0", out_valid, occupancy);
    end
    // Flush while an accept is happening at occupancy 1 discards the new entry.
    in_valid = 1'b1; out_ready = 1'b0; in_data = 32'hF; in_ctrl = 4'h9;
    tick();
    flush = 1'b1; in_data = 32'h10; in_ctrl = 4'hA;
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    tick();
    vectors++;
    if (out_valid !== 1'b0 || occupancy !== 2'd0 || out_ctrl !== 4'h0) begin
      miscompares++;
      $display("FAIL flush_acc got v=%b occ=%0d c=%h want 0 0 0", out_valid, occupancy, out_ctrl);
    end
  endtask

  task automatic test_bubble_ctrl();
    in_valid = 1'b1; out_ready = 1'b1; in_ctrl = 4'b1111; in_data = 32'h55;
    tick();
    in_valid = 1'b0;
    vectors++;
    if (out_valid !== 1'b1 || out_ctrl !== 4'b1111) begin
      miscompares++;
      $display("FAIL bubble_live got v=%b c=%b want 1 1111", out_valid, out_ctrl);
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      vectors++;
      if (out_valid !== 1'b0 || out_ctrl !== 4'b0000) begin
        miscompares++;
        $display("FAIL bubble_idle_%0d got v=%b c=%b want 0 0000", i, out_valid, out_ctrl);
      end
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0; in_valid = 1'b1;
    in_data = 32'h21; in_ctrl = 4'h1;
    tick();
    in_data = 32'h22; in_ctrl = 4'h2;
    tick();
    RST = 1'b1; in_data = 32'h23; in_ctrl = 4'h3;
    #1;
    vectors++;
    if (in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_mid_ready got %b want 0", in_ready);
    end
    tick();
    vectors++;
    if ({in_ready, out_valid, out_ctrl, out_data, occupancy} !== {1'b0, 1'b0, 4'h0, 32'h0, 2'd0}) begin
      miscompares++;
      $display("FAIL rst_mid_state got rdy=%b v=%b c=%h d=%h occ=%0d want 0 0 0 0 0",
               in_ready, out_valid, out_ctrl, out_data, occupancy);
    end
    RST = 1'b0; out_ready = 1'b1; in_data = 32'h24; in_ctrl = 4'h4;
    tick();
    in_valid = 1'b0;
    vectors++;
    if (out_valid !== 1'b1 || out_data !== 32'h24 || out_ctrl !== 4'h4) begin
      miscompares++;
      $display("FAIL rst_mid_first got v=%b d=%h c=%h want 1 24 4", out_valid, out_data, out_ctrl);
    end
    tick();
  endtask

  task automatic test_random();
    ent_t q[$];
    logic [3:0] exp_c;
    logic       exp_take;
    logic       exp_acc;
    int         size;
    q = {};
    for (int cyc = 0; cyc < 10000; cyc++) begin
      in_valid  = ($urandom_range(0, 9) < 6);
      out_ready = ($urandom_range(0, 9) < 5);
      flush     = ($urandom_range(0, 31) == 0);
      in_ctrl   = 4'($urandom);
      in_data   = $urandom;
      #1;
      size  = q.size();
      exp_c = (size > 0) ? q[0].c : 4'h0;
      vectors++;
      if ({in_ready, out_valid, occupancy, out_ctrl} !== {(size < 2), (size > 0), 2'(size), exp_c}) begin
        miscompares++;
        $display("FAIL rand_status cyc %0d got rdy=%b v=%b occ=%0d c=%h want %b %b %0d %h",
                 cyc, in_ready, out_valid, occupancy, out_ctrl, size < 2, size > 0, size, exp_c);
      end
      if (size > 0) begin
        vectors++;
        if (out_data !== q[0].d) begin
          miscompares++;
          $display("FAIL rand_data cyc %0d got %h want %h", cyc, out_data, q[0].d);
        end
      end
      exp_take = (size > 0) && out_ready;
      exp_acc  = in_valid && (size < 2);
      if (exp_take) void'(q.pop_front());
      if (exp_acc) q.push_back('{c: in_ctrl, d: in_data});
      if (flush) q = {};
      tick();
    end
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    tick(); tick();
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_bubble_ctrl();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pipe_reg_skid.md
Name: pipe_reg_skid

Overview:
- Parametrised elastic pipeline-stage register. It is the successor to the fixed inter-stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries a control bundle and a data bundle across one stage boundary, using valid/ready handshakes on both sides.
- A 2-entry skid buffer sustains one transfer per cycle under backpressure.
- Supports synchronous flush (bubble insertion) for branch/hazard recovery, and guarantees downstream never sees stale control bits while invalid.

Parameters:
- DATA_W, 32, width of data bundle (e.g. ALUOut/WriteData/PCBranch concatenated by the instantiating stage).
- CTRL_W, 4, width of control bundle (e.g. RegWrite, MemtoReg, MemWrite, Branch).
- BUBBLE_CTRL, {CTRL_W{1'b0}}, control value presented when no valid entry (bubble).

Ports:
- CLK  input  1  clock; all state changes on posedge.
- RST  input  1  reset.
- in_valid  input  1  upstream presents an entry.
- in_ready  output  1  stage can accept an entry.
- in_ctrl  input  CTRL_W  upstream control bundle.
- in_data  input  DATA_W  upstream data bundle.
- flush  input  1  discard all held entries and any entry accepted this cycle.
- out_valid  output  1  out_ctrl/out_data hold a valid entry.
- out_ready  input  1  downstream accepts this cycle.
- out_ctrl  output  CTRL_W  control bundle; BUBBLE_CTRL whenever out_valid=0.
- out_data  output  DATA_W  data bundle; value is don't-care when out_valid=0.
- occupancy  output  2  number of held entries (0, 1, 2).

Behaviour:
- One clock domain (CLK). RST is synchronous and active-high. Clock port is CLK; reset port is RST.

Reset:
- While RST=1 at a posedge, the following are set: main_valid=0, skid_valid=0, out_ctrl=BUBBLE_CTRL, out_data=0, occupancy=0.
- in_ready=0 while RST is high (combinational); in_ready=1 from the first cycle after RST deasserts.
- Reset overrides flush and all handshakes, including mid-transfer.

Storage:
- Main register (drives outputs) plus one skid register.
- in_ready = !skid_valid && !RST. in_ready is a pure register decode, so there is no combinational path from out_ready to in_ready.

Handshakes:
- acc = in_valid && in_ready.
- take = out_valid && out_ready.
- Inputs are sampled only on acc; outputs are held stable while out_valid && !out_ready.

Transitions (no flush), by occupancy:
- Occupancy 0: acc loads main. Latency is 1 cycle (in at edge N, out_valid at N+1).
- Occupancy 1, take && acc: main <= input. Occupancy stays 1; throughput is 1/cycle.
- Occupancy 1, take && !acc: occupancy goes to 0.
- Occupancy 1, !take && acc: skid <= input. Occupancy becomes 2 and in_ready falls next cycle.
- Occupancy 2, take: main <= skid, skid_valid=0, occupancy becomes 1. acc is impossible in this state.
- Occupancy 2, !take: hold.

Ordering and invariants:
- Strict FIFO order; no entry is lost or duplicated.
- out_valid is asserted if and only if main_valid=1.
- out_ctrl is forced to BUBBLE_CTRL when main_valid=0. This is registered, not gated combinationally.

Flush:
- Clears main_valid and skid_valid; out_ctrl <= BUBBLE_CTRL.
- An entry accepted in the same cycle (acc=1) is consumed and discarded.
- A take in the same cycle completes downstream; the entry is not replayed.
- out_data is not cleared by flush.
- occupancy=0 next cycle.

Test Plan:
- Reset then stream: RST 2 cycles; drive in_valid=1 with data 1..8, out_ready=1. Required: out_data 1..8 on consecutive cycles starting 1 cycle after the first accept; occupancy stays ≤1.
- Backpressure: out_ready=0 while data 0xA, 0xB are sent. Required: occupancy=2, in_ready=0, out_data held at 0xA. Release out_ready. Required: 0xA, then 0xB, then in_ready=1.
- Flush with full skid: occupancy=2 (0xC, 0xD) plus flush=1 with in_valid=1, data 0xE. Required: next cycle out_valid=0, out_ctrl=BUBBLE_CTRL, occupancy=0; 0xE is never emitted.
- Bubble control: CTRL_W=4, BUBBLE_CTRL=0, in_ctrl=4'b1111 accepted once, then in_valid=0. Required: out_ctrl=1111 for 1 cycle, then 0000 while out_valid=0.
- Reset mid-operation: occupancy=2, assert RST for 1 cycle with in_valid=1. Required: in_ready=0 during RST, all outputs at reset values; post-reset first output is the first entry accepted after reset.
- Random valid/ready (10k cycles) against a scoreboard FIFO. Required: exact in-order match, no out_ctrl≠BUBBLE_CTRL while out_valid=0.
